// File: rtl/sccomp_dataflow.sv
// Single-cycle MIPS-32 computer: CPU core, instruction ROM and data RAM.
// One instruction retires per clk_in edge; PC, register and RAM updates commit together.

module pcreg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);
  logic [31:0] data_out;

  // PC register; reset vector is the text segment base
  always_ff @(posedge clk_i) begin
    if (rst_i) data_out <= 32'h0040_0000;
    else       data_out <= d_i;
  end

  assign q_o = data_out;
endmodule

module regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic [31:0] rda_o,
  output logic [31:0] rdb_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);
  logic [31:0] array_reg [0:31];

  // Single write port; $0 is never written
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) array_reg[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      array_reg[wa_i] <= wd_i;
    end
  end

  assign rda_o = (ra_i == 5'd0) ? 32'h0 : array_reg[ra_i];
  assign rdb_o = (rb_i == 5'd0) ? 32'h0 : array_reg[rb_i];
endmodule

module sccpu_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [9:0]  dmem_idx_o,
  output logic [31:0] dmem_wdata_o,
  output logic        dmem_we_o,
  input  logic [31:0] dmem_rdata_i
);
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [5:0]  fn;
  logic [31:0] simm;
  logic [31:0] zimm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic [31:0] ea;
  logic [31:0] pc_d;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        mem_we;

  assign op   = inst_i[31:26];
  assign rs   = inst_i[25:21];
  assign rt   = inst_i[20:16];
  assign rd   = inst_i[15:11];
  assign sh   = inst_i[10:6];
  assign fn   = inst_i[5:0];
  assign simm = {{16{inst_i[15]}}, inst_i[15:0]};
  assign zimm = {16'h0, inst_i[15:0]};
  assign pc4  = pc_q + 32'd4;
  assign ea   = rs_val + simm;

  pcreg pcreg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  regfile cpu_ref (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ra_i  (rs),
    .rb_i  (rt),
    .rda_o (rs_val),
    .rdb_o (rt_val),
    .we_i  (wr_en),
    .wa_i  (wr_addr),
    .wd_i  (wr_data)
  );

  // Decode and execute; unknown encodings fall through as nop
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rt;
    wr_data = 32'h0;
    mem_we  = 1'b0;
    pc_d    = pc4;
    case (op)
      6'h00: begin
        wr_en   = 1'b1;
        wr_addr = rd;
        case (fn)
          6'h20, 6'h21: wr_data = rs_val + rt_val;
          6'h22, 6'h23: wr_data = rs_val - rt_val;
          6'h24: wr_data = rs_val & rt_val;
          6'h25: wr_data = rs_val | rt_val;
          6'h26: wr_data = rs_val ^ rt_val;
          6'h27: wr_data = ~(rs_val | rt_val);
          6'h2A: wr_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: wr_data = {31'h0, rs_val < rt_val};
          6'h00: wr_data = rt_val << sh;
          6'h02: wr_data = rt_val >> sh;
          6'h03: wr_data = $signed(rt_val) >>> sh;
          6'h04: wr_data = rt_val << rs_val[4:0];
          6'h06: wr_data = rt_val >> rs_val[4:0];
          6'h07: wr_data = $signed(rt_val) >>> rs_val[4:0];
          6'h08: begin
            wr_en = 1'b0;
            pc_d  = rs_val;
          end
          default: wr_en = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin
        wr_en   = 1'b1;
        wr_data = ea;
      end
      6'h0C: begin
        wr_en   = 1'b1;
        wr_data = rs_val & zimm;
      end
      6'h0D: begin
        wr_en   = 1'b1;
        wr_data = rs_val | zimm;
      end
      6'h0E: begin
        wr_en   = 1'b1;
        wr_data = rs_val ^ zimm;
      end
      6'h0F: begin
        wr_en   = 1'b1;
        wr_data = {inst_i[15:0], 16'h0};
      end
      6'h0A: begin
        wr_en   = 1'b1;
        wr_data = {31'h0, $signed(rs_val) < $signed(simm)};
      end
      6'h0B: begin
        wr_en   = 1'b1;
        wr_data = {31'h0, rs_val < simm};
      end
      6'h23: begin
        wr_en   = 1'b1;
        wr_data = dmem_rdata_i;
      end
      6'h2B: mem_we = 1'b1;
      6'h04: if (rs_val == rt_val) pc_d = pc4 + {simm[29:0], 2'b00};
      6'h05: if (rs_val != rt_val) pc_d = pc4 + {simm[29:0], 2'b00};
      6'h02: pc_d = {pc4[31:28], inst_i[25:0], 2'b00};
      6'h03: begin
        pc_d    = {pc4[31:28], inst_i[25:0], 2'b00};
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc4;
      end
      default: ;
    endcase
  end

  // RAM base 0x10010000 only touches bits above 11, so the index is ea[11:2]
  assign dmem_idx_o   = ea[11:2];
  assign dmem_wdata_o = rt_val;
  assign dmem_we_o    = mem_we & ~rst_i;
  assign pc_o         = pc_q;
endmodule

module sccomp_dataflow #(
  parameter logic [31:0] ROM_IMAGE [1024] = '{default: 32'h0}
) (
  input  logic        clk_in,
  input  logic        reset,
  output logic [31:0] inst,
  output logic [31:0] pc
);
  logic [9:0]  didx;
  logic [31:0] dwdata;
  logic        dwe;
  logic [31:0] drdata;
  logic [31:0] dmem_q [0:1023] = '{default: 32'h0};

  sccpu_core sccpu (
    .clk_i        (clk_in),
    .rst_i        (reset),
    .inst_i       (inst),
    .pc_o         (pc),
    .dmem_idx_o   (didx),
    .dmem_wdata_o (dwdata),
    .dmem_we_o    (dwe),
    .dmem_rdata_i (drdata)
  );

  // Text base 0x00400000 only touches bits above 11, so the index is pc[11:2]
  assign inst   = ROM_IMAGE[pc[11:2]];
  assign drdata = dmem_q[didx];

  // Data RAM write port; contents survive reset
  always_ff @(posedge clk_in) begin
    if (dwe) dmem_q[didx] <= dwdata;
  end
endmodule

// File: tb/tb_sccomp_dataflow.sv
// Directed program bench for sccomp_dataflow.
// Table of per-cycle expected pc/register values plus reset sequences.

module tb_sccomp_dataflow;
  localparam logic [31:0] IMG [1024] = '{
    0:  32'h3C011234,
    1:  32'h34215678,
    2:  32'h2402FFFF,
    3:  32'h3C031001,
    4:  32'h24040055,
    5:  32'hAC640004,
    6:  32'h8C650004,
    7:  32'h10000002,
    8:  32'h24080001,
    9:  32'h24080001,
    10: 32'h14000002,
    11: 32'h0C100015,
    12: 32'h3C028000,
    13: 32'h24000005,
    14: 32'h00023103,
    15: 32'h0002382B,
    16: 32'hFC000000,
    17: 32'h24090024,
    18: 32'h01225007,
    19: 32'h0040582A,
    20: 32'h08100014,
    21: 32'h03E00008,
    default: 32'h0
  };

  typedef struct {
    logic [31:0] pc;
    int          r;
    logic [31:0] val;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic [31:0] pc;
  int          n_cmp = 0;
  int          n_err = 0;
  vec_t        tbl [20];
  logic [31:0] act;
  logic [31:0] pidx;

  sccomp_dataflow #(.ROM_IMAGE(IMG)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .inst   (inst),
    .pc     (pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] rreg(input int r);
    return dut.sccpu.cpu_ref.array_reg[r];
  endfunction

  task automatic chk_pc(input string name, input logic [31:0] e);
    chk({name, ".pc"}, pc, e);
    chk({name, ".pcreg"}, dut.sccpu.pcreg.data_out, e);
    pidx = {22'h0, e[11:2]};
    chk({name, ".inst"}, inst, IMG[pidx]);
  endtask

  initial begin
    tbl[0]  = '{32'h00400004, 1,  32'h12340000};
    tbl[1]  = '{32'h00400008, 1,  32'h12345678};
    tbl[2]  = '{32'h0040000C, 2,  32'hFFFFFFFF};
    tbl[3]  = '{32'h00400010, 3,  32'h10010000};
    tbl[4]  = '{32'h00400014, 4,  32'h00000055};
    tbl[5]  = '{32'h00400018, 32, 32'h00000055};
    tbl[6]  = '{32'h0040001C, 5,  32'h00000055};
    tbl[7]  = '{32'h00400028, 8,  32'h00000000};
    tbl[8]  = '{32'h0040002C, -1, 32'h0};
    tbl[9]  = '{32'h00400054, 31, 32'h00400030};
    tbl[10] = '{32'h00400030, -1, 32'h0};
    tbl[11] = '{32'h00400034, 2,  32'h80000000};
    tbl[12] = '{32'h00400038, 0,  32'h00000000};
    tbl[13] = '{32'h0040003C, 6,  32'hF8000000};
    tbl[14] = '{32'h00400040, 7,  32'h00000001};
    tbl[15] = '{32'h00400044, 8,  32'h00000000};
    tbl[16] = '{32'h00400048, 9,  32'h00000024};
    tbl[17] = '{32'h0040004C, 10, 32'hF8000000};
    tbl[18] = '{32'h00400050, 11, 32'h00000001};
    tbl[19] = '{32'h00400050, 31, 32'h00400030};

    reset = 1'b1;
    repeat (3) step();
    chk_pc("reset", 32'h00400000);
    for (int r = 0; r < 32; r++) chk($sformatf("reset.r%0d", r), rreg(r), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      chk_pc($sformatf("v%0d", i), tbl[i].pc);
      if (tbl[i].r == 32) act = dut.dmem_q[1];
      else if (tbl[i].r >= 0) act = rreg(tbl[i].r);
      if (tbl[i].r >= 0)
        chk($sformatf("v%0d.val", i), act, tbl[i].val);
    end

    chk("ram1", dut.dmem_q[1], 32'h00000055);

    reset = 1'b1;
    step();
    chk_pc("rerst", 32'h00400000);
    chk("rerst.r1", rreg(1), 32'h0);
    chk("rerst.r31", rreg(31), 32'h0);
    chk("rerst.ram1", dut.dmem_q[1], 32'h00000055);
    reset = 1'b0;
    step();
    chk_pc("rerun", 32'h00400004);
    chk("rerun.r1", rreg(1), 32'h12340000);
    chk("rerun.r31", rreg(31), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
